// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first valid index at or after ptr_i, wrapping.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [IDW-1:0]     idx_o,
  output logic               found_o
);
  logic [IDW:0] pos;

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NUM_REQ)) pos = pos - (IDW+1)'(NUM_REQ);
      if (valid_i[pos[IDW-1:0]]) begin
        idx_o   = pos[IDW-1:0];
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_Tx among NUM_REQ byte sources.
// Optional send-to-done watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
`ifdef UART_ARB_TIMEOUT_EN
  parameter  int TIMEOUT_CYC = 65535,
`endif
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  input  logic [NUM_REQ-1:0][UART_DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  output logic                                  tx_send_o,
  output logic [UART_DATA_W-1:0]                tx_data_o,
  input  logic                                  tx_active_i,
  input  logic                                  tx_done_i,
  output logic [IDW-1:0]                        grant_id_o,
  output logic                                  busy_o,
  output logic                                  done_pulse_o
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                                  timeout_err_o
`endif
);
  arb_state_e                   state_q;
  logic [IDW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]               grant_id_q;
  logic [NUM_REQ-1:0]           req_ready_q;
  logic                         tx_send_q, done_pulse_q;
  logic [UART_DATA_W-1:0]       tx_data_q;
  logic [IDW-1:0]               pick_idx;
  logic                         pick_found;
  logic                         to_hit;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;

  // Completion on the last allowed cycle beats the watchdog.
  assign to_hit = (state_q != IDLE) && !tx_done_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
      if (to_hit) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      req_ready_q  <= '0;
      tx_send_q    <= 1'b0;
      tx_data_q    <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      done_pulse_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_found) begin
          tx_data_q   <= req_data_i[pick_idx];
          grant_id_q  <= pick_idx;
          req_ready_q <= NUM_REQ'(1) << pick_idx;
          tx_send_q   <= 1'b1;
          state_q     <= START;
        end
        START: begin
          if (tx_done_i) begin
            tx_send_q    <= 1'b0;
            done_pulse_q <= 1'b1;
            rr_ptr_q     <= rr_ptr_d;
            state_q      <= IDLE;
          end else if (to_hit) begin
            tx_send_q <= 1'b0;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= IDLE;
          end else if (tx_active_i) begin
            tx_send_q <= 1'b0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (tx_done_i) begin
            done_pulse_q <= 1'b1;
            rr_ptr_q     <= rr_ptr_d;
            state_q      <= IDLE;
          end else if (to_hit) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign tx_send_o    = tx_send_q;
  assign tx_data_o    = tx_data_q;
  assign grant_id_o   = grant_id_q;
  assign busy_o       = (state_q != IDLE);
  assign done_pulse_o = done_pulse_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_ready;
  logic             tx_send;
  logic [7:0]       tx_data;
  logic             tx_active, tx_done;
  logic [1:0]       grant_id;
  logic             busy, done_pulse;
`ifdef UART_ARB_TIMEOUT_EN
  logic             timeout_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .tx_send_o    (tx_send),
    .tx_data_o    (tx_data),
    .tx_active_i  (tx_active),
    .tx_done_i    (tx_done),
    .grant_id_o   (grant_id),
    .busy_o       (busy),
    .done_pulse_o (done_pulse)
`ifdef UART_ARB_TIMEOUT_EN
    , .timeout_err_o(timeout_err)
`endif
  );

  typedef struct {
    logic [3:0] valid;
    logic       act;
    logic       done;
    logic [3:0] e_rdy;
    logic       e_send;
    logic [7:0] e_data;
    logic [1:0] e_gid;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tv [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Waits for a grant, checks it, then completes the frame via tx_active/tx_done.
  task automatic do_frame(input int id, input logic [7:0] exp_byte);
    int w;
    logic [3:0] oh;
    w  = 0;
    oh = 4'b0001 << id;
    while (w < 8) begin
      tick();
      w++;
      if (|req_ready) break;
    end
    chk("grant_wait", w, 1);
    chk("frame_ready", req_ready, oh);
    chk("frame_gid", grant_id, id);
    chk("frame_data", tx_data, exp_byte);
    chk("frame_send", tx_send, 1);
    req_data[id] = exp_byte + 8'h01;
    tx_active = 1'b1;
    tick();
    chk("frame_busy_send", {busy, tx_send}, 2'b10);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    chk("frame_done", {done_pulse, busy}, 2'b10);
    chk("frame_hold", tx_data, exp_byte);
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; tx_active = 1'b0; tx_done = 1'b0;
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy_done", {busy, done_pulse}, 0);
    rst = 1'b0;

    // Single requester 2, byte A5, plus tx flags seen in IDLE.
    tv[0] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1, 1'b0};
    tv[1] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 1'b1, 1'b0};
    tv[2] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0};
    tv[3] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0};
    tv[4] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b1};
    tv[5] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b0};
    tv[6] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b0};
    req_data[2] = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      req_valid = tv[i].valid; tx_active = tv[i].act; tx_done = tv[i].done;
      tick();
      chk("tv_ready", req_ready, tv[i].e_rdy);
      chk("tv_send", tx_send, tv[i].e_send);
      chk("tv_data", tx_data, tv[i].e_data);
      chk("tv_gid", grant_id, tv[i].e_gid);
      chk("tv_busy", busy, tv[i].e_busy);
      chk("tv_done", done_pulse, tv[i].e_done);
    end
    tx_active = 1'b0; tx_done = 1'b0;

    // Reset while BUSY (rr_ptr is 3 here, requester 0 is reached by wrap).
    req_data[0] = 8'h3C;
    req_valid = 4'b0001;
    tick();
    chk("wrap_ready", req_ready, 4'b0001);
    req_valid = '0; tx_active = 1'b1;
    tick();
    chk("pre_rst_busy", {busy, tx_send}, 2'b10);
    tx_active = 1'b0; tx_done = 1'b1; rst = 1'b1;
    tick();
    chk("midrst_ready", req_ready, 0);
    chk("midrst_outs", {tx_send, tx_data, grant_id, busy, done_pulse}, 0);
    rst = 1'b0; tx_done = 1'b0;
    tick();
    chk("midrst_nodone", {done_pulse, busy}, 0);

    // All valid: strict rotation from 0 with per-requester byte streams.
    for (int i = 0; i < 4; i++) req_data[i] = 8'h40 + 8'(16 * i);
    req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) do_frame(f % 4, 8'h40 + 8'(16 * (f % 4)) + 8'(f / 4));

    // Sparse requesters: reach rr_ptr=2, then 1 and 3 valid gives 3 then 1.
    req_valid = 4'b0010;
    do_frame(1, 8'h52);
    req_valid = 4'b1010;
    do_frame(3, 8'h72);
    do_frame(1, 8'h53);

    // tx_done while still in START.
    req_valid = 4'b0100;
    tick();
    chk("early_ready", req_ready, 4'b0100);
    chk("early_data", tx_data, 8'h62);
    req_valid = '0; tx_done = 1'b1;
    tick();
    chk("early_done", {done_pulse, busy, tx_send}, 3'b100);
    tx_done = 1'b0;
    tick();
    chk("early_single", {done_pulse, busy, req_ready}, 0);

`ifdef UART_ARB_TIMEOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0011;
    tick();
    chk("to_grant", req_ready, 4'b0001);
    for (int k = 0; k < 15; k++) tick();
    chk("to_pre", {timeout_err, busy}, 2'b01);
    tick();
    chk("to_fire", {timeout_err, busy, tx_send, done_pulse}, 4'b1000);
    tick();
    chk("to_next", req_ready, 4'b0010);
    chk("to_next_gid", grant_id, 1);
    req_valid = '0; tx_done = 1'b1;
    tick();
    chk("to_sticky", {timeout_err, done_pulse}, 2'b11);
    tx_done = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
